// File: rtl/bec_slave_if.sv
// BEC-side responder: operand capture, key streaming and result return.
// Sequences one BEC core run per slv_enable rising edge.
module bec_slave_if #(
  parameter int WIDTH    = 163,
  parameter int KEY_BITS = 163
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_data,
  input  logic             trigLoad,
  input  logic [2:0]       load_status,
  input  logic [WIDTH-1:0] data_bus,
  input  logic             slv_enable,
  input  logic             ki,
  output logic             next_key,
  output logic [3:0]       bec_status,
  output logic             slv_done,
  output logic [WIDTH-1:0] result_bus,
  output logic             core_start,
  output logic [WIDTH-1:0] core_w1,
  output logic [WIDTH-1:0] core_z1,
  output logic [WIDTH-1:0] core_w2,
  output logic [WIDTH-1:0] core_z2,
  output logic [WIDTH-1:0] core_inv_w0,
  output logic [WIDTH-1:0] core_d,
  input  logic             core_key_req,
  output logic             core_key_bit,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_wout,
  input  logic [WIDTH-1:0] core_zout
);

  localparam int KW = $clog2(KEY_BITS + 1);

  localparam logic [3:0] ST_READY = 4'h8;
  localparam logic [3:0] ST_RUN   = 4'h1;
  localparam logic [3:0] ST_DONE  = 4'h4;
  localparam logic [3:0] ST_ERR   = 4'hE;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE1,
    DONE2
  } state_t;

  state_t           state;
  logic [5:0]       loaded_mask;
  logic [KW-1:0]    key_cnt;
  logic             err;
  logic             slv_enable_q;
  logic [WIDTH-1:0] wout_r;
  logic [WIDTH-1:0] zout_r;

  logic             se_rise;
  logic             cap;
  logic [5:0]       sel;
  logic             key_left;

  assign se_rise  = slv_enable & ~slv_enable_q;
  assign cap      = (state == IDLE) & load_data & trigLoad
                  & (load_status <= 3'd5);
  assign key_left = (key_cnt < KW'(KEY_BITS));

  assign next_key     = (state == RUN) & core_key_req & key_left;
  assign core_key_bit = (state == RUN) & key_left & ki;

  // One-hot decode of the operand being written this cycle.
  always_comb begin
    sel = '0;
    if (cap) sel = 6'd1 << load_status;
  end

  // Operand registers, written only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_w1     <= '0;
      core_z1     <= '0;
      core_w2     <= '0;
      core_z2     <= '0;
      core_inv_w0 <= '0;
      core_d      <= '0;
    end else begin
      if (sel[0]) core_w1     <= data_bus;
      if (sel[1]) core_z1     <= data_bus;
      if (sel[2]) core_w2     <= data_bus;
      if (sel[3]) core_z2     <= data_bus;
      if (sel[4]) core_inv_w0 <= data_bus;
      if (sel[5]) core_d      <= data_bus;
    end
  end

  // Edge detector for the start request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) slv_enable_q <= 1'b0;
    else     slv_enable_q <= slv_enable;
  end

  // Run sequencer with registered status and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bec_status  <= ST_READY;
      slv_done    <= 1'b0;
      core_start  <= 1'b0;
      result_bus  <= '0;
      loaded_mask <= '0;
      key_cnt     <= '0;
      err         <= 1'b0;
      wout_r      <= '0;
      zout_r      <= '0;
    end else begin
      core_start <= 1'b0;
      slv_done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cap) begin
            loaded_mask <= loaded_mask | sel;
            err         <= 1'b0;
            bec_status  <= ST_READY;
          end
          if (se_rise) begin
            // The mask check uses the value before any same-cycle capture.
            if (loaded_mask == 6'h3F) begin
              state      <= RUN;
              core_start <= 1'b1;
              err        <= 1'b0;
              key_cnt    <= '0;
              result_bus <= '0;
              bec_status <= ST_RUN;
            end else begin
              err        <= 1'b1;
              bec_status <= ST_ERR;
            end
          end
        end
        RUN: begin
          if (next_key) key_cnt <= key_cnt + KW'(1);
          if (core_done) begin
            wout_r     <= core_wout;
            zout_r     <= core_zout;
            result_bus <= core_wout;
            slv_done   <= 1'b1;
            bec_status <= ST_DONE;
            state      <= DONE1;
          end
        end
        DONE1: begin
          result_bus <= zout_r;
          state      <= DONE2;
        end
        DONE2: begin
          loaded_mask <= '0;
          bec_status  <= err ? ST_ERR : ST_READY;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
